// File: rtl/queue_dispatcher.sv
// Bank queue ticket issuer and two-teller dispatcher with open/drain/closed sequencing.
// All outputs registered; a request sampled on an edge shows immediately after that edge.
module queue_dispatcher #(
   parameter int TICKET_W   = 8,
   parameter int MAX_TICKET = 99,
   parameter int QDEPTH     = 15,
   parameter int CNT_W      = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bank_open,
   input  logic                customer_req,
   input  logic [1:0]          teller_en,
   input  logic [1:0]          teller_req,
   output logic [TICKET_W-1:0] issued_ticket,
   output logic [TICKET_W-1:0] serve0,
   output logic [TICKET_W-1:0] serve1,
   output logic [CNT_W-1:0]    queue_cnt,
   output logic                full,
   output logic                wait_flag,
   output logic                reject,
   output logic [1:0]          bank_state
);

   typedef enum logic [1:0] {
      CLOSED = 2'b00,
      OPEN   = 2'b01,
      DRAIN  = 2'b10
   } state_e;

   state_e              state_q, state_d;
   logic [TICKET_W-1:0] issued_q, issued_d;
   logic [TICKET_W-1:0] serve0_q, serve0_d;
   logic [TICKET_W-1:0] serve1_q, serve1_d;
   logic [TICKET_W-1:0] next_issue_q, next_issue_d;
   logic [TICKET_W-1:0] next_serve_q, next_serve_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rr_q, rr_d;
   logic                reject_q, reject_d;

   logic                issue;
   logic [1:0]          qual;
   logic [1:0]          granted;

   function automatic logic [TICKET_W-1:0] tk_inc(input logic [TICKET_W-1:0] t);
      return (t == TICKET_W'(MAX_TICKET)) ? TICKET_W'(1) : t + TICKET_W'(1);
   endfunction

   always_comb begin
      issue        = (state_q == OPEN) && customer_req && !full;
      qual         = teller_req & teller_en & {2{state_q != CLOSED}};
      granted      = 2'd0;
      serve0_d     = serve0_q;
      serve1_d     = serve1_q;
      next_serve_d = next_serve_q;
      rr_d         = rr_q;
      issued_d     = issued_q;
      next_issue_d = next_issue_q;
      state_d      = state_q;
      reject_d     = customer_req && !issue;

      if (issue) begin
         issued_d     = next_issue_q;
         next_issue_d = tk_inc(next_issue_q);
      end

      // Only tickets already waiting before this edge can be handed out.
      case (qual)
         2'b01: begin
            if (cnt_q != '0) begin
               serve0_d     = next_serve_q;
               next_serve_d = tk_inc(next_serve_q);
               granted      = 2'd1;
            end else begin
               serve0_d = '0;
            end
         end
         2'b10: begin
            if (cnt_q != '0) begin
               serve1_d     = next_serve_q;
               next_serve_d = tk_inc(next_serve_q);
               granted      = 2'd1;
            end else begin
               serve1_d = '0;
            end
         end
         2'b11: begin
            if (cnt_q >= CNT_W'(2)) begin
               serve0_d     = rr_q ? tk_inc(next_serve_q) : next_serve_q;
               serve1_d     = rr_q ? next_serve_q : tk_inc(next_serve_q);
               next_serve_d = tk_inc(tk_inc(next_serve_q));
               granted      = 2'd2;
            end else if (cnt_q == CNT_W'(1)) begin
               serve0_d     = rr_q ? '0 : next_serve_q;
               serve1_d     = rr_q ? next_serve_q : '0;
               next_serve_d = tk_inc(next_serve_q);
               granted      = 2'd1;
               rr_d         = ~rr_q;
            end else begin
               serve0_d = '0;
               serve1_d = '0;
            end
         end
         default: ;
      endcase

      if (!teller_en[0]) serve0_d = '0;
      if (!teller_en[1]) serve1_d = '0;

      cnt_d = cnt_q + CNT_W'(issue) - CNT_W'(granted);

      case (state_q)
         CLOSED:  if (bank_open) state_d = OPEN;
         OPEN:    if (!bank_open) state_d = (cnt_d == '0) ? CLOSED : DRAIN;
         DRAIN: begin
            if (bank_open)         state_d = OPEN;
            else if (cnt_d == '0)  state_d = CLOSED;
         end
         default: state_d = CLOSED;
      endcase

      // Closing wipes the displays and restarts numbering, overriding any final serve.
      if (state_q != CLOSED && state_d == CLOSED) begin
         serve0_d     = '0;
         serve1_d     = '0;
         issued_d     = '0;
         next_issue_d = TICKET_W'(1);
         next_serve_d = TICKET_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= CLOSED;
         issued_q     <= '0;
         serve0_q     <= '0;
         serve1_q     <= '0;
         next_issue_q <= TICKET_W'(1);
         next_serve_q <= TICKET_W'(1);
         cnt_q        <= '0;
         rr_q         <= 1'b0;
         reject_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         issued_q     <= issued_d;
         serve0_q     <= serve0_d;
         serve1_q     <= serve1_d;
         next_issue_q <= next_issue_d;
         next_serve_q <= next_serve_d;
         cnt_q        <= cnt_d;
         rr_q         <= rr_d;
         reject_q     <= reject_d;
      end
   end

   assign issued_ticket = issued_q;
   assign serve0        = serve0_q;
   assign serve1        = serve1_q;
   assign queue_cnt     = cnt_q;
   assign full          = (cnt_q == CNT_W'(QDEPTH));
   assign wait_flag     = (cnt_q != '0);
   assign reject        = reject_q;
   assign bank_state    = state_q;

endmodule

// File: tb/tb_queue_dispatcher.sv
// Directed bench for queue_dispatcher: ticket issue, round-robin serve, full/wrap, drain/close, async reset.
module tb_queue_dispatcher;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       bank_open = 1'b0;
   logic       customer_req = 1'b0;
   logic [1:0] teller_en = 2'b00;
   logic [1:0] teller_req = 2'b00;
   logic [7:0] issued_ticket, serve0, serve1;
   logic [3:0] queue_cnt;
   logic       full, wait_flag, reject;
   logic [1:0] bank_state;

   int n_assert = 0;
   int n_fail   = 0;

   queue_dispatcher dut (
      .clk          (clk),
      .rst          (rst),
      .bank_open    (bank_open),
      .customer_req (customer_req),
      .teller_en    (teller_en),
      .teller_req   (teller_req),
      .issued_ticket(issued_ticket),
      .serve0       (serve0),
      .serve1       (serve1),
      .queue_cnt    (queue_cnt),
      .full         (full),
      .wait_flag    (wait_flag),
      .reject       (reject),
      .bank_state   (bank_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock with optional single-cycle pulses; returns 1 time unit after the edge.
   task automatic tick(input logic c, input logic [1:0] t);
      customer_req = c;
      teller_req   = t;
      @(posedge clk);
      #1;
      customer_req = 1'b0;
      teller_req   = 2'b00;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " state"},  32'(bank_state),    0);
      chk({tag, " issued"}, 32'(issued_ticket), 0);
      chk({tag, " serve0"}, 32'(serve0),        0);
      chk({tag, " serve1"}, 32'(serve1),        0);
      chk({tag, " cnt"},    32'(queue_cnt),     0);
      chk({tag, " full"},   32'(full),          0);
      chk({tag, " wait"},   32'(wait_flag),     0);
      chk({tag, " reject"}, 32'(reject),        0);
   endtask

   initial begin
      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_all_zero("reset");
      rst = 1'b1;

      // Open and issue three tickets
      bank_open = 1'b1;
      tick(1'b0, 2'b00);
      chk("open state", 32'(bank_state), 1);
      tick(1'b1, 2'b00);
      chk("issue1", 32'(issued_ticket), 1);
      tick(1'b1, 2'b00);
      chk("issue2", 32'(issued_ticket), 2);
      tick(1'b1, 2'b00);
      chk("issue3", 32'(issued_ticket), 3);
      chk("cnt3", 32'(queue_cnt), 3);
      chk("wait3", 32'(wait_flag), 1);
      chk("state open", 32'(bank_state), 1);

      // Single teller, then both tellers with two waiting (rr at teller 0)
      teller_en = 2'b11;
      tick(1'b0, 2'b01);
      chk("single serve0", 32'(serve0), 1);
      chk("single cnt", 32'(queue_cnt), 2);
      tick(1'b0, 2'b11);
      chk("dual serve0", 32'(serve0), 2);
      chk("dual serve1", 32'(serve1), 3);
      chk("dual cnt", 32'(queue_cnt), 0);
      chk("dual wait", 32'(wait_flag), 0);

      // One waiting, both call: rr teller gets it, then pointer toggles
      tick(1'b1, 2'b00);
      chk("issue4", 32'(issued_ticket), 4);
      tick(1'b0, 2'b11);
      chk("rr1 serve0", 32'(serve0), 4);
      chk("rr1 serve1", 32'(serve1), 0);
      chk("rr1 cnt", 32'(queue_cnt), 0);
      tick(1'b1, 2'b00);
      chk("issue5", 32'(issued_ticket), 5);
      tick(1'b0, 2'b11);
      chk("rr2 serve1", 32'(serve1), 5);
      chk("rr2 serve0", 32'(serve0), 0);

      // Issue and serve in the same cycle on an empty queue
      tick(1'b1, 2'b01);
      chk("same-cycle serve0", 32'(serve0), 0);
      chk("same-cycle cnt", 32'(queue_cnt), 1);
      chk("same-cycle issued", 32'(issued_ticket), 6);
      tick(1'b0, 2'b01);
      chk("next-cycle serve0", 32'(serve0), 6);
      chk("next-cycle cnt", 32'(queue_cnt), 0);

      // Fill to QDEPTH with tickets 7..21, then one refused request
      for (int i = 0; i < 15; i++) tick(1'b1, 2'b00);
      chk("fill cnt", 32'(queue_cnt), 15);
      chk("fill full", 32'(full), 1);
      chk("fill issued", 32'(issued_ticket), 21);
      tick(1'b1, 2'b00);
      chk("full reject", 32'(reject), 1);
      chk("full cnt held", 32'(queue_cnt), 15);
      chk("full issued held", 32'(issued_ticket), 21);
      tick(1'b0, 2'b00);
      chk("reject one cycle", 32'(reject), 0);

      // Walk next_issue up to MAX_TICKET while serving 7..85
      tick(1'b0, 2'b01);
      chk("unfill serve0", 32'(serve0), 7);
      chk("unfill full", 32'(full), 0);
      for (int i = 0; i < 78; i++) tick(1'b1, 2'b01);
      chk("issued 99", 32'(issued_ticket), 99);
      chk("steady cnt", 32'(queue_cnt), 14);
      tick(1'b1, 2'b01);
      chk("issue wrap", 32'(issued_ticket), 1);
      chk("serve0 86", 32'(serve0), 86);

      // Serve 87..98 pairwise leaving tickets 99 and 1
      for (int i = 0; i < 6; i++) tick(1'b0, 2'b11);
      chk("pair serve0", 32'(serve0), 97);
      chk("pair serve1", 32'(serve1), 98);
      chk("pair cnt", 32'(queue_cnt), 2);

      // Drain sequence
      bank_open = 1'b0;
      tick(1'b0, 2'b00);
      chk("drain state", 32'(bank_state), 2);
      tick(1'b1, 2'b00);
      chk("drain reject", 32'(reject), 1);
      chk("drain cnt", 32'(queue_cnt), 2);
      chk("drain issued", 32'(issued_ticket), 1);
      tick(1'b0, 2'b01);
      chk("drain serve0", 32'(serve0), 99);
      chk("drain cnt1", 32'(queue_cnt), 1);
      chk("drain still", 32'(bank_state), 2);
      tick(1'b0, 2'b10);
      chk_all_zero("closed");
      tick(1'b1, 2'b11);
      chk("closed reject", 32'(reject), 1);
      chk("closed serve1", 32'(serve1), 0);
      chk("closed cnt", 32'(queue_cnt), 0);

      // Reopen restarts numbering
      bank_open = 1'b1;
      tick(1'b0, 2'b00);
      chk("reopen state", 32'(bank_state), 1);
      tick(1'b1, 2'b00);
      chk("reopen issue", 32'(issued_ticket), 1);
      tick(1'b0, 2'b01);
      chk("reopen serve0", 32'(serve0), 1);

      // Closing teller 0 forces idle and ignores its request
      tick(1'b1, 2'b00);
      teller_en = 2'b10;
      tick(1'b0, 2'b01);
      chk("teller off serve0", 32'(serve0), 0);
      chk("teller off cnt", 32'(queue_cnt), 1);
      tick(1'b1, 2'b00);
      chk("pre-reset cnt", 32'(queue_cnt), 2);
      chk("pre-reset issued", 32'(issued_ticket), 3);

      // Asynchronous reset between edges
      #1;
      rst = 1'b0;
      #2;
      chk_all_zero("async reset");
      @(posedge clk); #1;
      rst = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
